serial_adder: RTL and testbench

//   Bit-serial adder built around one instance of the existing single-bit full adder (fa).

---
 rtl/serial_adder.sv | 124 ++++++++++++
 tb/tb_serial_adder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell fed LSB first, with the carry held in a
// register between cycles. Result, carry-out and signed overflow latch at completion.

module fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   aSr_q, aSr_d;
  logic [WIDTH-1:0]   bSr_q, bSr_d;
  logic [WIDTH-1:0]   sumSr_q, sumSr_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic [WIDTH-1:0]   sumShift;
  logic               faS, faCo;

  fa u_fa (
    .x  (aSr_q[0]),
    .y  (bSr_q[0]),
    .ci (carry_q),
    .s  (faS),
    .co (faCo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      aSr_q   <= '0;
      bSr_q   <= '0;
      sumSr_q <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      aSr_q   <= aSr_d;
      bSr_q   <= bSr_d;
      sumSr_q <= sumSr_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // The visible result only changes on the final bit, so it survives a new start.
  always_comb begin
    state_d  = state_q;
    aSr_d    = aSr_q;
    bSr_d    = bSr_q;
    sumSr_d  = sumSr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    sumShift = sumSr_q >> 1;
    sumShift[WIDTH-1] = faS;
    case (state_q)
      IDLE: begin
        if (start) begin
          aSr_d   = a;
          bSr_d   = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        aSr_d   = aSr_q >> 1;
        bSr_d   = bSr_q >> 1;
        sumSr_d = sumShift;
        carry_d = faCo;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_d   = sumShift;
          cout_d  = faCo;
          ovf_d   = carry_q ^ faCo;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: an 8-bit instance checked against
// integer arithmetic, plus a 1-bit instance checked against the full-adder table.

module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst;
  logic       start8, cin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;
  logic       start1, a1, b1, cin1;
  logic       busy1, done1, sum1, cout1, ovf1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  // Reference: plain integer addition; signed overflow when like-signed operands
  // give a result of the opposite sign.
  function automatic logic [9:0] model8(input logic [7:0] x, input logic [7:0] y, input logic c);
    logic [8:0] full;
    logic       ov;
    full = {1'b0, x} + {1'b0, y} + {8'd0, c};
    ov   = (x[7] == y[7]) && (full[7] != x[7]);
    return {ov, full};
  endfunction

  // Launch one 8-bit add and wait (bounded) for done; lat counts edges after accept.
  task automatic doAdd8(input logic [7:0] x, input logic [7:0] y, input logic c,
                        output int lat, output logic [7:0] s, output logic co, output logic ov);
    @(negedge clk);
    a8 = x; b8 = y; cin8 = c; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    lat = 0;
    while (!done8 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    s = sum8; co = cout8; ov = ovf8;
  endtask

  task automatic test_reset();
    rst = 1'b1; start8 = 1'b0; start1 = 1'b0;
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy8, done8, sum8, cout8, ovf8} !== 12'd0) begin
      errors++;
      $display("[TB] FAIL reset8: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all zero",
               busy8, done8, sum8, cout8, ovf8);
    end
    checks++;
    if ({busy1, done1, sum1, cout1, ovf1} !== 5'd0) begin
      errors++;
      $display("[TB] FAIL reset1: got %b, want 00000", {busy1, done1, sum1, cout1, ovf1});
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [7:0] va[5] = '{8'd100, 8'd200, 8'hFF, 8'd127, 8'h80};
    logic [7:0] vb[5] = '{8'd27,  8'd100, 8'h00, 8'd1,   8'h80};
    logic       vc[5] = '{1'b0,   1'b0,   1'b1,  1'b0,   1'b0};
    logic [9:0] exp[5] = '{{1'b0, 9'd127}, {1'b0, 9'h12C}, {1'b0, 9'h100},
                           {1'b1, 9'h080}, {1'b1, 9'h100}};
    int lat;
    logic [7:0] s;
    logic co, ov;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (model8(va[i], vb[i], vc[i]) !== exp[i]) begin
        errors++;
        $display("[TB] FAIL model%0d: got %h, want %h", i, model8(va[i], vb[i], vc[i]), exp[i]);
      end
      doAdd8(va[i], vb[i], vc[i], lat, s, co, ov);
      checks++;
      if (lat !== 8) begin
        errors++;
        $display("[TB] FAIL latency%0d: got %0d, want 8", i, lat);
      end
      checks++;
      if ({ov, co, s} !== exp[i]) begin
        errors++;
        $display("[TB] FAIL directed%0d: got ovf=%b cout=%b sum=%h, want %h", i, ov, co, s, exp[i]);
      end
      @(negedge clk);
      checks++;
      if (done8 !== 1'b0 || {ovf8, cout8, sum8} !== exp[i]) begin
        errors++;
        $display("[TB] FAIL hold%0d: got done=%b result=%h, want done=0 result=%h",
                 i, done8, {ovf8, cout8, sum8}, exp[i]);
      end
    end
  endtask

  task automatic test_random();
    int lat;
    logic [7:0] x, y, s;
    logic c, co, ov;
    for (int i = 0; i < 40; i++) begin
      x = 8'($urandom); y = 8'($urandom); c = 1'($urandom);
      doAdd8(x, y, c, lat, s, co, ov);
      checks++;
      if (lat !== 8 || {ov, co, s} !== model8(x, y, c)) begin
        errors++;
        $display("[TB] FAIL random%0d: %h+%h+%b got lat=%0d result=%h, want lat=8 result=%h",
                 i, x, y, c, lat, {ov, co, s}, model8(x, y, c));
      end
    end
  endtask

  task automatic test_ignore_start();
    int pulses = 0;
    logic [7:0] s = '0;
    @(negedge clk);
    a8 = 8'd55; b8 = 8'd66; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    checks++;
    if (busy8 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_run: got %b, want 1", busy8);
    end
    repeat (2) @(negedge clk);
    a8 = 8'd1; b8 = 8'd2; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done8) begin
        pulses++;
        s = sum8;
      end
    end
    checks++;
    if (pulses !== 1 || s !== 8'd122) begin
      errors++;
      $display("[TB] FAIL ignore_start: got pulses=%0d sum=%0d, want pulses=1 sum=122", pulses, s);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    logic [7:0] s;
    logic co, ov;
    doAdd8(8'hF0, 8'hF0, 1'b1, lat, s, co, ov);
    @(negedge clk);
    a8 = 8'd9; b8 = 8'd8; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy8, done8, sum8, cout8, ovf8} !== 12'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all zero",
               busy8, done8, sum8, cout8, ovf8);
    end
    doAdd8(8'd200, 8'd100, 1'b0, lat, s, co, ov);
    checks++;
    if (lat !== 8 || {ov, co, s} !== model8(8'd200, 8'd100, 1'b0)) begin
      errors++;
      $display("[TB] FAIL after_reset: got lat=%0d result=%h, want lat=8 result=%h",
               lat, {ov, co, s}, model8(8'd200, 8'd100, 1'b0));
    end
  endtask

  task automatic test_rst_start();
    @(negedge clk);
    a8 = 8'd3; b8 = 8'd4; cin8 = 1'b0; start8 = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; start8 = 1'b0;
    checks++;
    if (busy8 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_wins: got busy=%b, want 0", busy8);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int gap = 0;
    int waited = 0;
    @(negedge clk);
    a8 = 8'd10; b8 = 8'd20; cin8 = 1'b0; start8 = 1'b1;
    while (!done8 && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    do begin
      @(negedge clk);
      gap++;
    end while (!done8 && gap < 30);
    start8 = 1'b0;
    checks++;
    if (gap !== 10 || sum8 !== 8'd30) begin
      errors++;
      $display("[TB] FAIL back_to_back: got gap=%0d sum=%0d, want gap=10 sum=30", gap, sum8);
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_width1();
    logic [2:0] vec[4] = '{3'd5, 3'd6, 3'd4, 3'd1};
    logic [1:0] want;
    logic       wantOv;
    int lat;
    for (int i = 0; i < 4; i++) begin
      want   = 2'({1'b0, vec[i][2]} + {1'b0, vec[i][1]} + {1'b0, vec[i][0]});
      wantOv = (vec[i][2] == vec[i][1]) && (want[0] != vec[i][2]);
      @(negedge clk);
      {a1, b1, cin1} = vec[i];
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      {a1, b1, cin1} = 3'($urandom);
      lat = 0;
      while (!done1 && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      checks++;
      if (lat !== 1 || {cout1, sum1} !== want || ovf1 !== wantOv) begin
        errors++;
        $display("[TB] FAIL width1_%0d: got lat=%0d cout/sum=%b ovf=%b, want lat=1 cout/sum=%b ovf=%b",
                 i, lat, {cout1, sum1}, ovf1, want, wantOv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_mid_run();
    test_rst_start();
    test_back_to_back();
    test_width1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
